// File: rtl/sort_result_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : sort_result_serializer_if
// Purpose  : Vector capture and element stream signals of the serializer.
// Revision : 1.0
// ============================================================================
interface sort_result_serializer_if #(
  parameter int NUM_VALS = 5,
  parameter int SIZE     = 16,
  parameter int DEPTH    = 4
);
  logic                         vec_valid;
  logic [NUM_VALS*SIZE-1:0]     vec_data;
  logic                         m_valid;
  logic                         m_ready;
  logic [SIZE-1:0]              m_data;
  logic [$clog2(NUM_VALS)-1:0]  m_index;
  logic                         m_last;
  logic [$clog2(DEPTH+1)-1:0]   space_avail;
  logic                         err_overflow;
  logic                         clear_err;

  // The serializer itself
  modport slave (
    input  vec_valid, vec_data, m_ready, clear_err,
    output m_valid, m_data, m_index, m_last, space_avail, err_overflow
  );

  // Sorter / downstream side
  modport master (
    output vec_valid, vec_data, m_ready, clear_err,
    input  m_valid, m_data, m_index, m_last, space_avail, err_overflow
  );
endinterface
`default_nettype wire

// File: rtl/sort_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sort_result_serializer
// Purpose  : Buffers sorted vectors in a vector FIFO and streams them out one
//            element per valid/ready beat with index and last tag.
// Revision : 1.0
// ============================================================================
module sort_result_serializer #(
  parameter int NUM_VALS  = 5,
  parameter int SIZE      = 16,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sort_result_serializer_if.slave bus
);
  localparam int c_IDX_W = $clog2(NUM_VALS);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_VEC_W = NUM_VALS * SIZE;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_VALS - 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  logic [c_VEC_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_IDX_W-1:0] r_elem_idx;
  logic               r_err;

  logic               w_valid;
  logic               w_xfer;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;
  logic [c_IDX_W-1:0] w_pos;
  logic [c_VEC_W-1:0] w_head;
  logic [SIZE-1:0]    w_elem;

  assign w_valid = (r_count != '0);
  assign w_xfer  = w_valid && bus.m_ready;
  assign w_pop   = w_xfer && (r_elem_idx == c_LAST_IDX);
  // A full FIFO still accepts when its head retires on the same edge
  assign w_wr    = bus.vec_valid && ((r_count != c_DEPTH_CNT) || w_pop);
  assign w_drop  = bus.vec_valid && !w_wr;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_pos = r_elem_idx;
    if (LSB_FIRST == 0) begin
      w_pos = c_LAST_IDX - r_elem_idx;
    end
  end

  always_comb begin
    w_elem = '0;
    for (int i = 0; i < NUM_VALS; i++) begin
      if (w_pos == c_IDX_W'(i)) begin
        w_elem = w_head[i*SIZE +: SIZE];
      end
    end
  end

  assign bus.m_valid      = w_valid;
  assign bus.m_data       = w_valid ? w_elem : '0;
  assign bus.m_index      = w_valid ? w_pos : '0;
  assign bus.m_last       = w_valid && (r_elem_idx == c_LAST_IDX);
  assign bus.space_avail  = c_DEPTH_CNT - r_count;
  assign bus.err_overflow = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_elem_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
      if (w_xfer) begin
        r_elem_idx <= w_pop ? '0 : r_elem_idx + c_IDX_W'(1);
      end
      // A drop outranks a same-cycle clear
      if (w_drop) begin
        r_err <= 1'b1;
      end else if (bus.clear_err) begin
        r_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.vec_data;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sort_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_result_serializer
// Purpose  : Scoreboard bench for the LSB-first and MSB-first serializers.
// Revision : 1.0
// ============================================================================
module tb_sort_result_serializer;
  localparam int NV = 5;
  localparam int SZ = 16;
  localparam int DP = 4;

  typedef struct packed {
    logic [SZ-1:0] data;
    logic [2:0]    index;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_result_serializer_if #(.NUM_VALS(NV), .SIZE(SZ), .DEPTH(DP)) bus_l ();
  sort_result_serializer_if #(.NUM_VALS(NV), .SIZE(SZ), .DEPTH(DP)) bus_m ();

  sort_result_serializer #(.NUM_VALS(NV), .SIZE(SZ), .DEPTH(DP), .LSB_FIRST(1)) u_dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l.slave)
  );

  sort_result_serializer #(.NUM_VALS(NV), .SIZE(SZ), .DEPTH(DP), .LSB_FIRST(0)) u_dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m.slave)
  );

  beat_t q_l[$];
  beat_t q_m[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  beat_t held_l, held_m;
  logic  stall_l = 1'b0;
  logic  stall_m = 1'b0;

  // Monitor: LSB-first DUT
  always @(negedge clk) begin
    beat_t got, exp_b;
    if (!rst_n) begin
      stall_l = 1'b0;
    end else begin
      got = '{data: bus_l.m_data, index: bus_l.m_index, last: bus_l.m_last};
      if (stall_l) begin
        n_cmp++;
        if (!bus_l.m_valid || got !== held_l) begin
          n_fail++;
          $display("FAIL hold_lsb: got v=%0b d=%0d i=%0d l=%0b, want v=1 d=%0d i=%0d l=%0b",
                   bus_l.m_valid, got.data, got.index, got.last, held_l.data, held_l.index, held_l.last);
        end
      end
      if (bus_l.m_valid && bus_l.m_ready) begin
        n_cmp++;
        if (q_l.size() == 0) begin
          n_fail++;
          $display("FAIL beat_lsb: got unexpected d=%0d i=%0d, want no beat", got.data, got.index);
        end else begin
          exp_b = q_l.pop_front();
          if (got !== exp_b) begin
            n_fail++;
            $display("FAIL beat_lsb: got d=%0d i=%0d l=%0b, want d=%0d i=%0d l=%0b",
                     got.data, got.index, got.last, exp_b.data, exp_b.index, exp_b.last);
          end
        end
      end
      stall_l = bus_l.m_valid && !bus_l.m_ready;
      held_l  = got;
    end
  end

  // Monitor: MSB-first DUT
  always @(negedge clk) begin
    beat_t got, exp_b;
    if (!rst_n) begin
      stall_m = 1'b0;
    end else begin
      got = '{data: bus_m.m_data, index: bus_m.m_index, last: bus_m.m_last};
      if (stall_m) begin
        n_cmp++;
        if (!bus_m.m_valid || got !== held_m) begin
          n_fail++;
          $display("FAIL hold_msb: got v=%0b d=%0d i=%0d, want v=1 d=%0d i=%0d",
                   bus_m.m_valid, got.data, got.index, held_m.data, held_m.index);
        end
      end
      if (bus_m.m_valid && bus_m.m_ready) begin
        n_cmp++;
        if (q_m.size() == 0) begin
          n_fail++;
          $display("FAIL beat_msb: got unexpected d=%0d i=%0d, want no beat", got.data, got.index);
        end else begin
          exp_b = q_m.pop_front();
          if (got !== exp_b) begin
            n_fail++;
            $display("FAIL beat_msb: got d=%0d i=%0d l=%0b, want d=%0d i=%0d l=%0b",
                     got.data, got.index, got.last, exp_b.data, exp_b.index, exp_b.last);
          end
        end
      end
      stall_m = bus_m.m_valid && !bus_m.m_ready;
      held_m  = got;
    end
  end

  function automatic logic [NV*SZ-1:0] mkvec(input int base, input int stp);
    logic [NV*SZ-1:0] v;
    for (int i = 0; i < NV; i++) v[i*SZ +: SZ] = SZ'(base + stp * i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_l(input logic [NV*SZ-1:0] v, input bit accept);
    if (accept) begin
      for (int i = 0; i < NV; i++)
        q_l.push_back('{data: v[i*SZ +: SZ], index: 3'(i), last: (i == NV - 1)});
    end
    bus_l.vec_valid = 1'b1;
    bus_l.vec_data  = v;
    step();
    bus_l.vec_valid = 1'b0;
  endtask

  task automatic write_m(input logic [NV*SZ-1:0] v);
    for (int k = 0; k < NV; k++)
      q_m.push_back('{data: v[(NV-1-k)*SZ +: SZ], index: 3'(NV - 1 - k), last: (k == NV - 1)});
    bus_m.vec_valid = 1'b1;
    bus_m.vec_data  = v;
    step();
    bus_m.vec_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus_l.m_ready = 1'b0;
    write_l(mkvec(1, 1), 1);
    n_cmp++;
    if (bus_l.m_valid !== 1'b1 || bus_l.m_data !== 16'd1) begin
      n_fail++;
      $display("FAIL first_beat_latency: got v=%0b d=%0d, want v=1 d=1", bus_l.m_valid, bus_l.m_data);
    end
    for (int v = 0; v < 4; v++) write_l(mkvec(20 + v, 1), v < 3);
    n_cmp++;
    if (bus_l.err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_err: got %0b, want 1", bus_l.err_overflow);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_l.m_valid !== 1'b0 || bus_l.m_data !== '0 || bus_l.m_index !== '0 || bus_l.m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got v=%0b d=%0d i=%0d l=%0b, want all 0",
               bus_l.m_valid, bus_l.m_data, bus_l.m_index, bus_l.m_last);
    end
    n_cmp++;
    if (bus_l.space_avail !== 3'd4 || bus_l.err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_status: got space=%0d err=%0b, want space=4 err=0",
               bus_l.space_avail, bus_l.err_overflow);
    end
    q_l.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int nv;
    bus_l.m_ready = 1'b1;
    write_l(mkvec(10, 10), 1);
    n_cmp++;
    if (bus_l.m_valid !== 1'b1 || bus_l.m_data !== 16'd10 || bus_l.m_index !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_first: got v=%0b d=%0d i=%0d, want v=1 d=10 i=0",
               bus_l.m_valid, bus_l.m_data, bus_l.m_index);
    end
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_l.m_valid) nv++;
    end
    n_cmp++;
    if (nv != 5 || q_l.size() != 0 || bus_l.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_stream: got valid_cycles=%0d left=%0d v=%0b, want 5 0 0",
               nv, q_l.size(), bus_l.m_valid);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit pat [8] = '{1, 0, 0, 1, 0, 1, 1, 1};
    bus_l.m_ready = 1'b0;
    write_l(mkvec(10, 10), 1);
    foreach (pat[k]) begin
      bus_l.m_ready = pat[k];
      step();
    end
    n_cmp++;
    if (q_l.size() != 0 || bus_l.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_done: got left=%0d v=%0b, want 0 0", q_l.size(), bus_l.m_valid);
    end
  endtask

  task automatic test_overflow();
    bus_l.m_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      write_l(mkvec(100 * (v + 1), 1), v < 4);
      if (v == 3) begin
        n_cmp++;
        if (bus_l.space_avail !== 3'd0 || bus_l.err_overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_full: got space=%0d err=%0b, want 0 0", bus_l.space_avail, bus_l.err_overflow);
        end
      end
    end
    n_cmp++;
    if (bus_l.space_avail !== 3'd0 || bus_l.err_overflow !== 1'b1 || bus_l.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: got space=%0d err=%0b v=%0b, want 0 1 1",
               bus_l.space_avail, bus_l.err_overflow, bus_l.m_valid);
    end
    bus_l.clear_err = 1'b1;
    step();
    bus_l.clear_err = 1'b0;
    n_cmp++;
    if (bus_l.err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got err=%0b, want 0", bus_l.err_overflow);
    end
    bus_l.m_ready = 1'b1;
    repeat (25) step();
    n_cmp++;
    if (q_l.size() != 0 || bus_l.space_avail !== 3'd4 || bus_l.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drain: got left=%0d space=%0d v=%0b, want 0 4 0",
               q_l.size(), bus_l.space_avail, bus_l.m_valid);
    end
  endtask

  task automatic test_full_pop_write();
    bus_l.m_ready = 1'b0;
    for (int v = 0; v < 4; v++) write_l(mkvec(500 + 10 * v, 2), 1);
    bus_l.m_ready = 1'b1;
    repeat (4) step();
    n_cmp++;
    if (bus_l.m_last !== 1'b1 || bus_l.space_avail !== 3'd0) begin
      n_fail++;
      $display("FAIL fpw_head_last: got last=%0b space=%0d, want 1 0", bus_l.m_last, bus_l.space_avail);
    end
    write_l(mkvec(900, 3), 1);
    n_cmp++;
    if (bus_l.err_overflow !== 1'b0 || bus_l.space_avail !== 3'd0) begin
      n_fail++;
      $display("FAIL fpw_accept: got err=%0b space=%0d, want 0 0", bus_l.err_overflow, bus_l.space_avail);
    end
    repeat (30) step();
    n_cmp++;
    if (q_l.size() != 0 || bus_l.space_avail !== 3'd4 || bus_l.err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fpw_drain: got left=%0d space=%0d err=%0b, want 0 4 0",
               q_l.size(), bus_l.space_avail, bus_l.err_overflow);
    end
  endtask

  task automatic test_msb_reset();
    bus_m.m_ready = 1'b1;
    write_m(mkvec(10, 10));
    n_cmp++;
    if (bus_m.m_data !== 16'd50 || bus_m.m_index !== 3'd4 || bus_m.m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_first: got d=%0d i=%0d l=%0b, want d=50 i=4 l=0",
               bus_m.m_data, bus_m.m_index, bus_m.m_last);
    end
    repeat (2) step();
    n_cmp++;
    if (q_m.size() != 3 || bus_m.m_data !== 16'd30 || bus_m.m_index !== 3'd2) begin
      n_fail++;
      $display("FAIL msb_beat3: got left=%0d d=%0d i=%0d, want 3 30 2",
               q_m.size(), bus_m.m_data, bus_m.m_index);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_m.m_valid !== 1'b0 || bus_m.space_avail !== 3'd4) begin
      n_fail++;
      $display("FAIL msb_reset: got v=%0b space=%0d, want 0 4", bus_m.m_valid, bus_m.space_avail);
    end
    q_m.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (bus_m.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_after_reset: got v=%0b, want 0", bus_m.m_valid);
    end
  endtask

  initial begin
    bus_l.vec_valid = 1'b0; bus_l.vec_data = '0; bus_l.m_ready = 1'b0; bus_l.clear_err = 1'b0;
    bus_m.vec_valid = 1'b0; bus_m.vec_data = '0; bus_m.m_ready = 1'b0; bus_m.clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_full_pop_write();
    test_msb_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
